// File: rtl/mul8_sequencer.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 array multiplier over four
// nibble passes, with a valid/ready handshake on both the operand and product sides.
module mul8_sequencer #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [7:0]  done_cnt
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [15:0] acc;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [15:0] pass_term;

    // Unsigned 4x4 array multiplier: one row of partial products per multiplier bit.
    function automatic logic [7:0] mul4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                sum = sum + ({4'b0000, x} << i);
            end
        end
        return sum;
    endfunction

    // step[0] selects the multiplicand nibble, step[1] the multiplier nibble.
    always_comb begin
        nib_a     = step[0] ? a_q[7:4] : a_q[3:0];
        nib_b     = step[1] ? b_q[7:4] : b_q[3:0];
        pp        = mul4x4(nib_a, nib_b);
        pass_term = {8'h00, pp};
        case (step)
            2'd0:    pass_term = {8'h00, pp};
            2'd1,
            2'd2:    pass_term = {4'h0, pp, 4'h0};
            default: pass_term = {pp, 8'h00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 2'd0;
            acc      <= 16'h0000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            done_cnt <= 8'h00;
        end else if (clr) begin
            state <= IDLE;
            step  <= 2'd0;
            acc   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= 16'h0000;
                        step <= 2'd0;
                        if (SKIP_ZERO && ((a == 8'h00) || (b == 8'h00))) begin
                            state <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc  <= acc + pass_term;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        done_cnt <= done_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = acc;

endmodule

// File: tb/tb_mul8_sequencer.sv
// Directed bench for mul8_sequencer: one task per scenario, expected values hand-computed
// or taken from a plain a*b reference.
module tb_mul8_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, busy;
    logic [15:0] product;
    logic [7:0]  done_cnt;
    logic        in_ready_ns, out_valid_ns, busy_ns;
    logic [15:0] product_ns;
    logic [7:0]  done_cnt_ns;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul8_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .busy(busy), .done_cnt(done_cnt)
    );

    mul8_sequencer #(.SKIP_ZERO(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_ns),
        .a(a), .b(b), .out_valid(out_valid_ns), .out_ready(out_ready), .product(product_ns),
        .busy(busy_ns), .done_cnt(done_cnt_ns)
    );

    // Presents one operand pair for a single edge, then scrambles the operand inputs.
    // edges counts the accept edge as 1 and stops on the edge that raises out_valid.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, output int edges);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got %b exp 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (product !== 16'h0000 || done_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_values got product %h cnt %h exp 0000 00", product, done_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int e;
        out_ready = 1'b1;
        run_op(8'h12, 8'h34, e);
        checks++;
        if (e !== 5) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 5", e);
        end
        checks++;
        if (product !== 16'h03A8) begin
            errors++;
            $display("FAIL basic_product got %h exp 03a8", product);
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'h01 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handoff got cnt %h rdy %b vld %b exp 01 1 0", done_cnt, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int e;
        logic stable;
        out_ready = 1'b0;
        run_op(8'hFF, 8'hFF, e);
        checks++;
        if (e !== 5 || product !== 16'hFE01) begin
            errors++;
            $display("FAIL bp_result got lat %0d product %h exp 5 fe01", e, product);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || product !== 16'hFE01 || done_cnt !== 8'h01) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got %b exp 1", stable);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'h02 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got cnt %h vld %b exp 02 0", done_cnt, out_valid);
        end
    endtask

    task automatic test_skip_zero();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'h00;
        b = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'h77;
        checks++;
        if (out_valid !== 1'b1 || product !== 16'h0000) begin
            errors++;
            $display("FAIL skip_fast got vld %b product %h exp 1 0000", out_valid, product);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid_ns !== 1'b0 || busy_ns !== 1'b1) begin
            errors++;
            $display("FAIL noskip_early got vld %b busy %b exp 0 1", out_valid_ns, busy_ns);
        end
        @(negedge clk);
        checks++;
        if (out_valid_ns !== 1'b1 || product_ns !== 16'h0000) begin
            errors++;
            $display("FAIL noskip_result got vld %b product %h exp 1 0000", out_valid_ns, product_ns);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'h03 || done_cnt_ns !== 8'h03) begin
            errors++;
            $display("FAIL skip_count got %h %h exp 03 03", done_cnt, done_cnt_ns);
        end
    endtask

    task automatic test_clr();
        int e;
        logic never;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || done_cnt !== 8'h03) begin
            errors++;
            $display("FAIL clr_abort got flags %b cnt %h exp 100 03", {in_ready, out_valid, busy}, done_cnt);
        end
        never = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || done_cnt !== 8'h03) never = 1'b0;
        end
        checks++;
        if (never !== 1'b1) begin
            errors++;
            $display("FAIL clr_quiet got %b exp 1", never);
        end
        run_op(8'h03, 8'h07, e);
        checks++;
        if (e !== 5 || product !== 16'h0015) begin
            errors++;
            $display("FAIL clr_next got lat %0d product %h exp 5 0015", e, product);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int e;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'h77;
        b = 8'h99;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 16'h0000 || done_cnt !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got flags %b product %h cnt %h exp 100 0000 00",
                     {in_ready, out_valid, busy}, product, done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h10, e);
        checks++;
        if (e !== 5 || product !== 16'h0100) begin
            errors++;
            $display("FAIL reset_next got lat %0d product %h exp 5 0100", e, product);
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'h01) begin
            errors++;
            $display("FAIL reset_count got %h exp 01", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  xa, xb;
        logic [15:0] exp_p;
        logic [7:0]  exp_cnt;
        int          waited, exp_wait, bad_p, bad_t;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 8'h00;
        bad_p = 0;
        bad_t = 0;
        for (int i = 0; i < 256; i++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            if (i % 16 == 3) xa = 8'h00;
            if (i % 16 == 9) xb = 8'h00;
            if (i == 5) begin xa = 8'hFF; xb = 8'hFF; end
            exp_p = 16'(xa) * 16'(xb);
            exp_wait = ((i == 0) ? 0 : 1) + (((xa == 8'h00) || (xb == 8'h00)) ? 1 : 5);
            in_valid = 1'b1;
            a = xa;
            b = xb;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!out_valid && waited < 20);
            if (product !== exp_p) begin
                bad_p++;
                if (bad_p <= 4) $display("FAIL b2b_product[%0d] got %h exp %h", i, product, exp_p);
            end
            if (waited !== exp_wait) begin
                bad_t++;
                if (bad_t <= 4) $display("FAIL b2b_interval[%0d] got %0d exp %0d", i, waited, exp_wait);
            end
            exp_cnt = exp_cnt + 8'd1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad_p != 0) begin
            errors++;
            $display("FAIL b2b_products got %0d bad exp 0", bad_p);
        end
        checks++;
        if (bad_t != 0) begin
            errors++;
            $display("FAIL b2b_intervals got %0d bad exp 0", bad_t);
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== exp_cnt || done_cnt !== 8'h00) begin
            errors++;
            $display("FAIL b2b_wrap got %h exp 00", done_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_skip_zero();
        test_clr();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul8_sequencer.md
MUL8_SEQUENCER -- requirements
Module: mul8_sequencer

Interface
REQ-001 Parameter SKIP_ZERO, default 1, meaning: when 1, a zero operand bypasses the multiply passes.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 clr  input  1  synchronous abort; active-high.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts an operand pair.
REQ-007 a  input  8  multiplicand, unsigned.
REQ-008 b  input  8  multiplier, unsigned.
REQ-009 out_valid  output  1  product present.
REQ-010 out_ready  input  1  consumer takes the product.
REQ-011 product  output  16  a*b, unsigned.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done_cnt  output  8  count of products taken by the consumer; wraps modulo 256.

Function
REQ-014 The block SHALL contain exactly one 4x4 unsigned combinational array multiplier and SHALL compute the 8x8 product through that multiplier only.
REQ-015 The state machine SHALL have three states: IDLE, MUL and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-017 Accept: on an edge with state IDLE and in_valid=1, the block SHALL latch a and b, clear the 16-bit accumulator, set step=0 and enter MUL.
REQ-018 MUL, one pass per cycle, accumulator += pass result:
- step0: a[3:0]*b[3:0], shifted 0.
- step1: a[7:4]*b[3:0], shifted 4.
- step2: a[3:0]*b[7:4], shifted 4.
- step3: a[7:4]*b[7:4], shifted 8.
REQ-019 Accumulation SHALL be 16-bit with no truncation; the final sum never exceeds 0xFE01.
REQ-020 On the step3 edge the block SHALL enter DONE. out_valid SHALL therefore rise exactly 5 edges after the accept edge.
REQ-021 If SKIP_ZERO=1 and a==0 or b==0 at accept, the block SHALL go from IDLE directly to DONE with product=0. out_valid SHALL rise on the edge after the accept edge.
REQ-022 In DONE, product and out_valid SHALL hold stable while out_ready=0.
REQ-023 In DONE with out_ready=1, the block SHALL return to IDLE and increment done_cnt (0xFF wraps to 0x00).
REQ-024 A new pair SHALL NOT be accepted in the same cycle as a handoff, so the minimum issue interval is 6 cycles, or 2 cycles on the skip path.
REQ-025 Operand inputs SHALL be ignored outside the accept cycle; changes during MUL or DONE SHALL NOT affect product.
REQ-026 product SHALL present the accumulator value and is defined only while out_valid=1.
REQ-027 clr=1 SHALL force IDLE on the next edge from any state and discard any in-flight or unconsumed result, without incrementing done_cnt.
REQ-028 clr SHALL take priority over accept and handoff in the same cycle.

Reset
REQ-029 While rst_n=0, regardless of clk, the block SHALL hold: state=IDLE, step=0, accumulator=0, done_cnt=0x00.
REQ-030 While rst_n=0 the outputs SHALL be in_ready=1, out_valid=0, busy=0, product=0x0000.
REQ-031 Assertion of rst_n mid-operation SHALL abandon the operation with no output; the first accept is permitted on the first edge after rst_n deasserts.

Verification
REQ-032 Accept a=0x12, b=0x34 with out_ready=1 -> out_valid rises 5 edges after accept, product=0x03A8, done_cnt=0x01, in_ready returns the next cycle.
REQ-033 Accept a=0xFF, b=0xFF with out_ready=0 for 10 cycles, then 1 -> product=0xFE01 held stable throughout DONE; exactly one done_cnt increment.
REQ-034 SKIP_ZERO=1, accept a=0x00, b=0x5A -> out_valid one edge after accept, product=0x0000. With SKIP_ZERO=0 -> 5 edges, product=0x0000.
REQ-035 Accept a=0xA5, b=0x3C, then assert clr at step2 -> IDLE next edge, out_valid never rises, done_cnt unchanged. The following a=0x03, b=0x07 yields 0x0015.
REQ-036 Drive rst_n=0 asynchronously between edges during MUL -> outputs reach reset values immediately. After release, a=0x10, b=0x10 yields 0x0100.
REQ-037 256 back-to-back random transactions against a reference model -> all products match, and done_cnt wraps to 0x00.
